// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a
// multi-cycle MULT/DIV hold, with a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instruction_id_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_Rt_i,
    input  logic        branch_taken_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        bubble_o,
    output logic        IF_flush_o,
    output logic        stall_busy_o,
    output logic [15:0] stall_cycles_o
);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_q, stall_d;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       usesRt;
    logic       isMd;
    logic       loadUse;
    logic       unusedBits;

    assign op         = Instruction_id_i[31:26];
    assign rs         = Instruction_id_i[25:21];
    assign rt         = Instruction_id_i[20:16];
    assign funct      = Instruction_id_i[5:0];
    assign unusedBits = ^Instruction_id_i[15:6];

    assign usesRt  = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign isMd    = (op == 6'h00) && ((funct == 6'h18) || (funct == 6'h1A));
    assign loadUse = ID_EX_MemRead_i && (ID_EX_Rt_i != 5'd0) &&
                     ((ID_EX_Rt_i == rs) || (usesRt && (ID_EX_Rt_i == rt)));

    // Controls are combinational; reset overrides them directly so they change
    // the moment rst_n falls, without waiting for a clock edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        bubble_o      = 1'b0;
        IF_flush_o    = 1'b0;
        stall_busy_o  = 1'b0;
        if (!rst_n) begin
            PC_Write_o = 1'b0;
            bubble_o   = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken_i) begin
                        IF_flush_o = 1'b1;
                        bubble_o   = 1'b1;
                    end else if (loadUse) begin
                        PC_Write_o    = 1'b0;
                        IF_ID_Write_o = 1'b0;
                        bubble_o      = 1'b1;
                    end else if (isMd && (MD_LATENCY > 1)) begin
                        state_d = MD_BUSY;
                        cnt_d   = CNT_W'(MD_LATENCY - 1);
                    end
                end
                MD_BUSY: begin
                    PC_Write_o    = 1'b0;
                    IF_ID_Write_o = 1'b0;
                    bubble_o      = 1'b1;
                    stall_busy_o  = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!PC_Write_o && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: the driver queues hand-computed
// expectations each cycle and a negedge monitor pops and compares them.
module tb_hazard_stall_unit;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] ADD_8   = 32'h010A_4820;
    localparam logic [31:0] LW_8    = 32'h8D28_0000;
    localparam logic [31:0] BEQ_1_8 = 32'h1028_0000;
    localparam logic [31:0] MULT_89 = 32'h0109_0018;
    localparam logic [31:0] DIV_89  = 32'h0109_001A;

    // ctrl bit order: {PC_Write, IF_ID_Write, bubble, IF_flush, stall_busy}
    localparam logic [4:0] C_RST   = 5'b01100;
    localparam logic [4:0] C_PASS  = 5'b11000;
    localparam logic [4:0] C_LU    = 5'b00100;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_BUSY  = 5'b00101;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [15:0] sc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instrId;
    logic        memRead;
    logic [4:0]  exRt;
    logic        branchTaken;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        bubble;
    logic        ifFlush;
    logic        stallBusy;
    logic [15:0] stallCycles;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Instruction_id_i (instrId),
        .ID_EX_MemRead_i  (memRead),
        .ID_EX_Rt_i       (exRt),
        .branch_taken_i   (branchTaken),
        .PC_Write_o       (pcWrite),
        .IF_ID_Write_o    (ifIdWrite),
        .bubble_o         (bubble),
        .IF_flush_o       (ifFlush),
        .stall_busy_o     (stallBusy),
        .stall_cycles_o   (stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One cycle of stimulus: change inputs just after the edge and queue the
    // response expected while they are held.
    task automatic applyStimulus(input string name, input logic rst, input logic [31:0] instr,
                                 input logic mr, input logic [4:0] rtEx, input logic br,
                                 input logic [4:0] ctrl, input logic [15:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = rst;
        instrId     = instr;
        memRead     = mr;
        exRt        = rtEx;
        branchTaken = br;
        e.name = name;
        e.ctrl = ctrl;
        e.sc   = sc;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [4:0] act;
        act = {pcWrite, ifIdWrite, bubble, ifFlush, stallBusy};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL %s ctrl: actual=%b required=%b", e.name, act, e.ctrl);
        end
        checks++;
        if (stallCycles !== e.sc) begin
            errors++;
            $display("[TB] FAIL %s stall_cycles: actual=%h required=%h", e.name, stallCycles, e.sc);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        rst_n       = 1'b0;
        instrId     = NOP;
        memRead     = 1'b0;
        exRt        = 5'd0;
        branchTaken = 1'b0;

        applyStimulus("reset0",     1'b0, NOP,     1'b0, 5'd0,  1'b0, C_RST,  16'd0);
        applyStimulus("reset1",     1'b0, NOP,     1'b0, 5'd0,  1'b0, C_RST,  16'd0);
        applyStimulus("release",    1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd0);

        applyStimulus("lu_rs",      1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'd0);
        applyStimulus("lu_after",   1'b1, ADD_8,   1'b0, 5'd8,  1'b0, C_PASS, 16'd1);
        applyStimulus("rt_zero",    1'b1, ADD_8,   1'b1, 5'd0,  1'b0, C_PASS, 16'd1);
        applyStimulus("lw_dest",    1'b1, LW_8,    1'b1, 5'd8,  1'b0, C_PASS, 16'd1);
        applyStimulus("lu_beq_rt",  1'b1, BEQ_1_8, 1'b1, 5'd8,  1'b0, C_LU,   16'd1);
        applyStimulus("pass1",      1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd2);
        applyStimulus("lu_add_rt",  1'b1, ADD_8,   1'b1, 5'd10, 1'b0, C_LU,   16'd2);
        applyStimulus("pass2",      1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd3);

        applyStimulus("mult_issue", 1'b1, MULT_89, 1'b0, 5'd0,  1'b0, C_PASS, 16'd3);
        applyStimulus("mult_busy1", 1'b1, NOP,     1'b0, 5'd0,  1'b0, C_BUSY, 16'd3);
        applyStimulus("busy_br_ign",1'b1, ADD_8,   1'b1, 5'd8,  1'b1, C_BUSY, 16'd4);
        applyStimulus("mult_busy3", 1'b1, NOP,     1'b0, 5'd0,  1'b0, C_BUSY, 16'd5);
        applyStimulus("mult_done",  1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd6);

        applyStimulus("flush_all",  1'b1, MULT_89, 1'b1, 5'd8,  1'b1, C_FLUSH,16'd6);
        applyStimulus("flush_after",1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd6);

        applyStimulus("div_issue",  1'b1, DIV_89,  1'b0, 5'd0,  1'b0, C_PASS, 16'd6);
        applyStimulus("div_busy1",  1'b1, MULT_89, 1'b0, 5'd0,  1'b0, C_BUSY, 16'd6);
        applyStimulus("div_busy2",  1'b1, NOP,     1'b0, 5'd0,  1'b0, C_BUSY, 16'd7);
        applyStimulus("div_busy3",  1'b1, NOP,     1'b0, 5'd0,  1'b0, C_BUSY, 16'd8);
        applyStimulus("div_done",   1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd9);

        applyStimulus("md_issue",   1'b1, MULT_89, 1'b0, 5'd0,  1'b0, C_PASS, 16'd9);
        applyStimulus("md_busy1",   1'b1, NOP,     1'b0, 5'd0,  1'b0, C_BUSY, 16'd9);
        applyStimulus("md_busy2",   1'b1, NOP,     1'b0, 5'd0,  1'b0, C_BUSY, 16'd10);
        applyStimulus("mid_reset",  1'b0, NOP,     1'b0, 5'd0,  1'b0, C_RST,  16'd0);
        applyStimulus("post_rst",   1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd0);
        applyStimulus("post_rst2",  1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'd0);

        // Continuous load-use stall walks the counter up to saturation.
        applyStimulus("sat_start",  1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'd0);
        repeat (65532) @(posedge clk);
        applyStimulus("sat_fffd",   1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'hFFFD);
        applyStimulus("sat_fffe",   1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'hFFFE);
        applyStimulus("sat_ffff",   1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'hFFFF);
        applyStimulus("sat_hold1",  1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'hFFFF);
        applyStimulus("sat_hold2",  1'b1, ADD_8,   1'b1, 5'd8,  1'b0, C_LU,   16'hFFFF);
        applyStimulus("sat_end",    1'b1, NOP,     1'b0, 5'd0,  1'b0, C_PASS, 16'hFFFF);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d pending required=0 pending", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
